// File: rtl/mux_nto1_reg.sv
// mux_nto1_reg
// ------------
// Registered N-channel, WIDTH-bit multiplexer with a valid/ready output.
// A sample is captured whenever a capture is requested and the output
// register is free (empty, or being drained in the same cycle). The channel
// comes either from the direct select input or from an internal round-robin
// scan counter.
//
// Parameters:
//   WIDTH  data bits per channel
//   NCH    number of input channels (2..256)
//   SEL_W  select width, 2**SEL_W >= NCH
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   din        flattened channel inputs, channel k = din[k*WIDTH +: WIDTH]
//   sel        channel select used in direct mode
//   mode       0 = direct select, 1 = auto-scan
//   en         request a new sample capture
//   out_ready  consumer ready
//   dout       registered selected data
//   dout_valid dout holds an unconsumed sample
//   ch_out     channel index the held sample came from
//   sel_err    held sample came from an out-of-range direct select
//   scan_wrap  held sample is the last channel of a scan sweep

module mux_nto1_reg #(
  parameter int WIDTH = 8,
  parameter int NCH   = 8,
  parameter int SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 mode,
  input  logic                 en,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic [SEL_W-1:0]     ch_out,
  output logic                 sel_err,
  output logic                 scan_wrap
);

  // One extra bit so NCH itself is representable when 2**SEL_W == NCH.
  localparam logic [SEL_W:0]   NCH_EXT = (SEL_W+1)'(NCH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NCH-1);

  logic             adv;
  logic [SEL_W-1:0] scan_cnt;
  logic [SEL_W-1:0] ch;
  logic             out_of_range;
  logic [WIDTH-1:0] ch_data;

  // Capture when asked and the output slot is empty or draining this cycle.
  // The scan counter never leaves 0..NCH-1, so only a direct select can be
  // out of range.
  always_comb begin
    adv          = en && (!dout_valid || out_ready);
    ch           = mode ? scan_cnt : sel;
    out_of_range = !mode && ({1'b0, sel} >= NCH_EXT);
  end

  // Channel selection written as a compare-per-channel loop so that select
  // codes beyond the last channel never form an out-of-range part-select.
  always_comb begin
    ch_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch == SEL_W'(k)) begin
        ch_data = din[k*WIDTH +: WIDTH];
      end
    end
  end

  // Output register: loads on a capture, otherwise only the valid flag
  // drops when the consumer takes the held sample. All other fields hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      ch_out     <= '0;
      sel_err    <= 1'b0;
      scan_wrap  <= 1'b0;
    end else if (adv) begin
      dout       <= out_of_range ? '0 : ch_data;
      dout_valid <= 1'b1;
      ch_out     <= ch;
      sel_err    <= out_of_range;
      scan_wrap  <= mode && (scan_cnt == LAST_CH);
    end else if (dout_valid && out_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // Scan counter: parked at 0 whenever direct mode is selected so every
  // sweep begins at channel 0; steps on each capture in scan mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else if (!mode) begin
      scan_cnt <= '0;
    end else if (adv) begin
      scan_cnt <= (scan_cnt == LAST_CH) ? '0 : scan_cnt + SEL_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// tb_mux_nto1_reg
// ---------------
// Drives an 8-channel and a 6-channel instance of mux_nto1_reg with the same
// control stimulus and checks both every cycle against a behavioural model.
// Directed sequences pin the model with literal expectations, followed by a
// randomized phase.

module tb_mux_nto1_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] din8;
  logic [47:0] din6;
  logic [2:0]  sel;
  logic        mode, en, out_ready;

  logic [7:0]  dout8, dout6;
  logic        valid8, valid6;
  logic [2:0]  ch8, ch6;
  logic        err8, err6, wrap8, wrap6;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  logic [7:0] chan_data [8];

  // Model state, index 0 = 8-channel instance, index 1 = 6-channel instance
  logic [7:0] m_dout  [2];
  logic       m_valid [2];
  logic [2:0] m_ch    [2];
  logic       m_err   [2];
  logic       m_wrap  [2];
  int         m_scan  [2];
  int         m_nch   [2] = '{8, 6};

  always #5 clk = ~clk;

  mux_nto1_reg #(.WIDTH(8), .NCH(8), .SEL_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din8), .sel(sel), .mode(mode), .en(en),
    .out_ready(out_ready), .dout(dout8), .dout_valid(valid8), .ch_out(ch8),
    .sel_err(err8), .scan_wrap(wrap8)
  );

  mux_nto1_reg #(.WIDTH(8), .NCH(6), .SEL_W(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .din(din6), .sel(sel), .mode(mode), .en(en),
    .out_ready(out_ready), .dout(dout6), .dout_valid(valid6), .ch_out(ch6),
    .sel_err(err6), .scan_wrap(wrap6)
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Inputs change just after the falling edge so they are stable at the
  // next rising edge; each call therefore spans exactly one capture edge.
  task automatic applyStimulus(input logic r, input logic m, input logic e,
                               input logic rdy, input logic [2:0] s,
                               input bit new_data);
    @(negedge clk);
    #1;
    rst_n     = r;
    mode      = m;
    en        = e;
    out_ready = rdy;
    sel       = s;
    if (new_data) begin
      for (int k = 0; k < 8; k++) chan_data[k] = 8'($urandom);
    end
    for (int k = 0; k < 8; k++) din8[k*8 +: 8] = chan_data[k];
    for (int k = 0; k < 6; k++) din6[k*8 +: 8] = chan_data[k];
  endtask

  // Behavioural model: a sample slot plus a modulo-NCH scan position.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_dout[i]  <= '0;
        m_valid[i] <= 1'b0;
        m_ch[i]    <= '0;
        m_err[i]   <= 1'b0;
        m_wrap[i]  <= 1'b0;
        m_scan[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit take;
        int c;
        take = en && (!m_valid[i] || out_ready);
        c    = mode ? m_scan[i] : int'(sel);
        if (take) begin
          m_dout[i]  <= (c >= m_nch[i]) ? 8'h00 : chan_data[c];
          m_err[i]   <= (c >= m_nch[i]);
          m_ch[i]    <= 3'(c);
          m_wrap[i]  <= mode && (c == m_nch[i] - 1);
          m_valid[i] <= 1'b1;
        end else if (m_valid[i] && out_ready) begin
          m_valid[i] <= 1'b0;
        end
        if (!mode)     m_scan[i] <= 0;
        else if (take) m_scan[i] <= (m_scan[i] + 1) % m_nch[i];
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("dout8",  dout8,  m_dout[0]);
      checkOutput("valid8", valid8, m_valid[0]);
      checkOutput("ch8",    ch8,    m_ch[0]);
      checkOutput("err8",   err8,   m_err[0]);
      checkOutput("wrap8",  wrap8,  m_wrap[0]);
      checkOutput("dout6",  dout6,  m_dout[1]);
      checkOutput("valid6", valid6, m_valid[1]);
      checkOutput("ch6",    ch6,    m_ch[1]);
      checkOutput("err6",   err6,   m_err[1]);
      checkOutput("wrap6",  wrap6,  m_wrap[1]);
    end
  end

  initial begin
    rst_n = 1'b0; mode = 1'b0; en = 1'b0; out_ready = 1'b0; sel = '0;
    for (int k = 0; k < 8; k++) chan_data[k] = 8'hA0 + 8'(k);
    for (int k = 0; k < 8; k++) din8[k*8 +: 8] = chan_data[k];
    for (int k = 0; k < 6; k++) din6[k*8 +: 8] = chan_data[k];

    repeat (2) @(negedge clk);
    checkOutput("reset_dout",  dout8,  8'h00);
    checkOutput("reset_valid", valid8, 1'b0);
    checkOutput("reset_ch",    ch8,    3'd0);
    chk_en = 1'b1;

    // Direct select sweep
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 1, 1, 3'(k), 0);
      @(negedge clk);
      checkOutput("direct_dout", dout8, 32'hA0 + k);
      checkOutput("direct_ch",   ch8,   k);
      checkOutput("direct_err",  err8,  1'b0);
    end
    checkOutput("oor_dout", dout6, 8'h00);
    checkOutput("oor_ch",   ch6,   3'd7);
    checkOutput("oor_err",  err6,  1'b1);
    applyStimulus(1, 0, 1, 1, 3'd2, 0);
    @(negedge clk);
    checkOutput("oor_recover_dout", dout6, 8'hA2);
    checkOutput("oor_recover_err",  err6,  1'b0);

    // Asynchronous reset while a sample is held
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_dout",  dout8,  8'h00);
    checkOutput("async_rst_valid", valid8, 1'b0);
    checkOutput("async_rst_ch",    ch6,    3'd0);

    // Backpressure in scan mode
    applyStimulus(1, 0, 0, 1, 3'd0, 0);
    applyStimulus(1, 1, 1, 0, 3'd0, 0);
    repeat (5) @(negedge clk);
    checkOutput("stall_dout",  dout8,  8'hA0);
    checkOutput("stall_ch",    ch8,    3'd0);
    checkOutput("stall_valid", valid8, 1'b1);
    applyStimulus(1, 1, 1, 1, 3'd0, 0);
    @(negedge clk);
    checkOutput("resume_dout1", dout8, 8'hA1);
    checkOutput("resume_ch1",   ch6,   3'd1);
    @(negedge clk);
    checkOutput("resume_dout2", dout8, 8'hA2);
    checkOutput("resume_ch2",   ch8,   3'd2);

    // Free-running scan across the wrap, then a one-cycle direct excursion
    repeat (10) @(negedge clk);
    applyStimulus(1, 0, 1, 1, 3'd3, 0);
    applyStimulus(1, 1, 1, 1, 3'd0, 0);
    @(negedge clk);
    checkOutput("rescan_ch8",   ch8,   3'd0);
    checkOutput("rescan_dout6", dout6, 8'hA0);

    // Bubble: consumer drains with no new request
    applyStimulus(1, 1, 0, 1, 3'd0, 0);
    @(negedge clk);
    checkOutput("bubble_valid", valid8, 1'b0);
    checkOutput("bubble_dout",  dout8,  8'hA1);
    applyStimulus(1, 1, 1, 1, 3'd0, 0);
    @(negedge clk);
    checkOutput("bubble_revalid", valid8, 1'b1);
    checkOutput("bubble_next",    dout8,  8'hA2);

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 299) != 0),
                    ($urandom_range(0, 9) > 2),
                    ($urandom_range(0, 9) > 2),
                    ($urandom_range(0, 9) > 3),
                    3'($urandom_range(0, 7)),
                    ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
